// File: rtl/dbg_trace_buffer.sv
// Retirement trace capture: dedupes consecutive PCs into an FWFT FIFO with a saturating drop
// counter. Define TRACE_LOOP_HALT_EN to freeze capture on a `jal x0, 0` self-loop.
module dbg_trace_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_en,
  input  logic [31:0]           dbg_pc,
  input  logic [31:0]           dbg_instruction,
  input  logic [31:0]           dbg_result,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_pc,
  output logic [31:0]           rd_instruction,
  output logic [31:0]           rd_result,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DROP_W-1:0]     drop_count,
  output logic                  halted
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = 1;
  localparam logic [DROP_W-1:0] DropOne = 1;

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [31:0]         last_pc_q, last_pc_d;
  logic                have_last_q, have_last_d;
  logic                halted_q, halted_d;
  logic [95:0]         mem_q [Depth];
  logic [95:0]         head;
  logic                empty, full, push, pop, wr_en;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
            (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    push  = trace_en && !halted_q && (!have_last_q || (dbg_pc != last_pc_q));
    pop   = !empty && rd_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    wr_en = push && (!full || pop);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_d      = drop_q;
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)   rd_ptr_d = rd_ptr_q + PtrOne;
    if (push && !wr_en && (drop_q != '1)) drop_d = drop_q + DropOne;
    if (trace_en && !halted_q) begin
      last_pc_d   = dbg_pc;
      have_last_d = 1'b1;
    end
`ifdef TRACE_LOOP_HALT_EN
    halted_d = halted_q || (push && (dbg_instruction == 32'h0000_006F));
`else
    halted_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= '0;
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      halted_q    <= halted_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {dbg_pc, dbg_instruction, dbg_result};
  end

  always_comb begin
    head           = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    rd_valid       = !empty;
    rd_pc          = rd_valid ? head[95:64] : '0;
    rd_instruction = rd_valid ? head[63:32] : '0;
    rd_result      = rd_valid ? head[31:0]  : '0;
    count          = wr_ptr_q - rd_ptr_q;
    drop_count     = drop_q;
    halted         = halted_q;
  end

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Self-checking bench for dbg_trace_buffer: queue-based reference model plus directed cases.
module tb_dbg_trace_buffer;

  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned DropW = 4;  // narrow so saturation is reachable
  localparam int unsigned DropMax = 15;
`ifdef TRACE_LOOP_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trace_en = 1'b0;
  logic [31:0]       dbg_pc = '0, dbg_instruction = '0, dbg_result = '0;
  logic              rd_valid, rd_ready = 1'b0;
  logic [31:0]       rd_pc, rd_instruction, rd_result;
  logic [DepthLog2:0] count;
  logic [DropW-1:0]  drop_count;
  logic              halted;

  int tests = 0;
  int fails = 0;

  dbg_trace_buffer #(.DEPTH_LOG2(DepthLog2), .DROP_W(DropW)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .dbg_pc(dbg_pc),
    .dbg_instruction(dbg_instruction), .dbg_result(dbg_result), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instruction(rd_instruction),
    .rd_result(rd_result), .count(count), .drop_count(drop_count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] res;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_drop;
  bit          m_halted, m_have_last;
  logic [31:0] m_last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one update per edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_drop = 0;
      m_halted = 1'b0;
      m_have_last = 1'b0;
      m_last_pc = '0;
    end else begin
      bit   do_push;
      ent_t e;
      do_push = trace_en && !m_halted && (!m_have_last || dbg_pc != m_last_pc);
      if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (do_push) begin
        e.pc = dbg_pc; e.ins = dbg_instruction; e.res = dbg_result;
        if (m_q.size() < Depth) m_q.push_back(e);
        else if (m_drop < DropMax) m_drop++;
      end
      if (trace_en && !m_halted) begin
        m_last_pc = dbg_pc;
        m_have_last = 1'b1;
      end
      if (HaltEn && do_push && dbg_instruction == 32'h0000_006F) m_halted = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("halted", 32'(halted), 32'(m_halted));
      if (m_q.size() > 0) begin
        chk("rd_pc", rd_pc, m_q[0].pc);
        chk("rd_instruction", rd_instruction, m_q[0].ins);
        chk("rd_result", rd_result, m_q[0].res);
      end
    end
  end

  task automatic drive(input logic [31:0] pc);
    dbg_pc = pc;
    dbg_instruction = pc ^ 32'hA5A5_0000;
    dbg_result = ~pc;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trace_en = 1'b0;
    rd_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset count", 32'(count), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_pc", rd_pc, 32'd0);

    // Distinct PCs, then one pop.
    trace_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'(i * 4));
      tick(1);
    end
    trace_en = 1'b0;
    chk("three count", 32'(count), 32'd3);
    chk("three rd_valid", 32'(rd_valid), 32'd1);
    chk("three head", rd_pc, 32'h0);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    chk("pop head", rd_pc, 32'h4);
    chk("pop count", 32'(count), 32'd2);
    rd_ready = 1'b1;
    tick(3);
    rd_ready = 1'b0;
    chk("drained", 32'(count), 32'd0);

    // Dedupe a held PC.
    trace_en = 1'b1;
    drive(32'h10);
    tick(5);
    drive(32'h14);
    tick(1);
    trace_en = 1'b0;
    chk("dedupe count", 32'(count), 32'd2);
    chk("dedupe head", rd_pc, 32'h10);
    rd_ready = 1'b1;
    tick(1);
    chk("dedupe second", rd_pc, 32'h14);
    tick(1);
    rd_ready = 1'b0;

    // Overflow: 20 distinct PCs into 16 slots.
    trace_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h100 + 32'(i * 4));
      tick(1);
    end
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf drop", 32'(drop_count), 32'd4);
    chk("ovf head", rd_pc, 32'h100);

    // Push and pop together while full.
    rd_ready = 1'b1;
    drive(32'h200);
    tick(1);
    rd_ready = 1'b0;
    chk("full pp count", 32'(count), 32'd16);
    chk("full pp drop", 32'(drop_count), 32'd4);
    chk("full pp head", rd_pc, 32'h104);

    // Drop counter saturates.
    for (int i = 0; i < 15; i++) begin
      drive(32'h400 + 32'(i * 4));
      tick(1);
    end
    chk("drop sat", 32'(drop_count), 32'd15);
    trace_en = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 16 && rd_valid; i++) begin
      chk("drain order", rd_pc, (i == 15) ? 32'h200 : 32'h104 + 32'(i * 4));
      tick(1);
    end
    rd_ready = 1'b0;

    // Async reset mid-stream with five stored entries.
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'h300 + 32'(i * 4));
      tick(1);
    end
    trace_en = 1'b0;
    chk("pre-reset count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async rd_valid", 32'(rd_valid), 32'd0);
    tick(1);
    rst_n = 1'b1;
    trace_en = 1'b1;
    drive(32'h310);
    tick(1);
    trace_en = 1'b0;
    chk("post-reset same pc", 32'(count), 32'd1);
    chk("post-reset head", rd_pc, 32'h310);

`ifdef TRACE_LOOP_HALT_EN
    do_reset();
    trace_en = 1'b1;
    drive(32'h3C);
    tick(1);
    drive(32'h40);
    dbg_instruction = 32'h0000_006F;
    tick(1);
    drive(32'h44);
    tick(1);
    drive(32'h48);
    tick(1);
    trace_en = 1'b0;
    chk("halt flag", 32'(halted), 32'd1);
    chk("halt count", 32'(count), 32'd2);
    rd_ready = 1'b1;
    tick(1);
    chk("halt drain head", rd_pc, 32'h40);
    tick(1);
    chk("halt drained", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
`endif

    // Randomized traffic with varying consumer pressure.
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned rdy_pct;
      rdy_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        trace_en = ($urandom_range(0, 3) != 0);
        dbg_pc = 32'($urandom_range(0, 7) * 4);
        dbg_instruction = $urandom;
        dbg_result = $urandom;
        rd_ready = ($urandom_range(0, 99) < rdy_pct);
        tick(1);
      end
    end
    trace_en = 1'b0;
    rd_ready = 1'b1;
    tick(Depth + 2);
    chk("final empty", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbg_trace_buffer.md
# dbg_trace_buffer

Retirement trace capture block that sits directly downstream of `processor` and consumes its `DEBUG_PC`, `DEBUG_INSTRUCTION` and `DEBUG_RESULT` outputs. Each clock it samples the triple and appends a new entry when the PC changes. Entries are stored in a first-word-fall-through FIFO, which a bench or host drains through a valid/ready port. A saturating drop counter records entries lost to a full buffer, and an optional self-loop detector freezes capture when the program parks on `jal x0, 0`.

## Interface
- `DEPTH_LOG2`, default 4: buffer depth is 2^DEPTH_LOG2 entries (16 by default).
- `DROP_W`, default 16: width of the saturating drop counter.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `trace_en`, input, 1: capture enable, sampled each cycle.
- `dbg_pc`, input, 32: PC of the instruction retiring this cycle.
- `dbg_instruction`, input, 32: the retiring instruction word.
- `dbg_result`, input, 32: the retiring instruction's result.
- `rd_valid`, output, 1: the head entry is presented on `rd_*`.
- `rd_ready`, input, 1: consumer accepts the head entry.
- `rd_pc`, `rd_instruction`, `rd_result`, output, 32 each: the head entry.
- `count`, output, DEPTH_LOG2+1: number of stored entries.
- `drop_count`, output, DROP_W: entries lost to a full buffer; saturates at all-ones.
- `halted`, output, 1: the self-loop detector has fired.

## Operation
- Reset (`rst_n`=0, takes effect immediately, independent of `clk`) clears the following:
  - read and write pointers to 0, so `count`=0 and `rd_valid`=0;
  - `drop_count` to 0 and `halted` to 0;
  - `rd_*` data outputs to 0;
  - the `have_last` flag to 0 and `last_pc` to 0.
- Capture condition, evaluated each cycle: `push` = `trace_en` & !`halted` & (!`have_last` | `dbg_pc` != `last_pc`).
- When `trace_en` is 1 and `halted` is 0, `last_pc` takes `dbg_pc` and `have_last` is set to 1. Both update whether or not the entry was actually stored.
- Consecutive identical PCs are logged once, so a self-loop produces a single entry.
- Pop condition: `pop` = `rd_valid` & `rd_ready`.
- Storage uses a circular buffer with pointers DEPTH_LOG2+1 bits wide.
  - Pointers wrap modulo 2^DEPTH_LOG2 on the address bits; the MSB distinguishes full from empty.
  - Empty when the pointers are fully equal.
  - Full when the address bits are equal and the MSBs differ.
- Boundary cases:
  - Push while full and no pop: the entry is discarded; `drop_count` increments unless it is already all-ones.
  - Push and pop in the same cycle while full: both proceed, `count` stays at 2^DEPTH_LOG2, and there is no drop.
  - Push and pop in the same cycle while empty: only the push takes effect (`rd_valid` was 0).
  - `trace_en` falling mid-stream: capture stops, but stored entries remain readable.
- `rd_*` always reflects the head entry whenever `rd_valid`=1. While `rd_valid`=0 its value is don't-care.

## Timing
- A sample accepted at rising edge N is visible as `rd_valid`=1 with its data after edge N (zero-wait FWFT from an empty buffer).
- Throughput is one push and one pop per cycle.
- `count` and `drop_count` are registered and reflect all pushes, pops and drops of edge N immediately after edge N.
- `rd_valid` depends only on registered state. There is no combinational path from `rd_ready` to `rd_valid`.
- A reset asserted mid-stream drops all stored entries asynchronously. The first edge after deassertion behaves as the first post-reset sample (`have_last`=0).

## Configuration
- `TRACE_LOOP_HALT_EN` defined: the self-loop detector is compiled in.
  - It fires when a push occurs with `dbg_instruction` == 32'h0000006F.
  - That entry is stored (or counted as dropped if the buffer is full), and `halted` is set to 1 at the same edge.
  - `halted` then blocks all further pushes until reset. Reads continue unaffected.
- `TRACE_LOOP_HALT_EN` undefined: the detector is not compiled in and `halted` is tied to 0.

## Test plan
- Post-reset distinct PCs: `trace_en`=1, PCs 0,4,8 on three edges, `rd_ready`=0.
  - Required: `count`=3, `rd_valid`=1, head entry `rd_pc`=0.
  - Then pulse `rd_ready` for one edge: `rd_pc`=4, `count`=2.
- Dedupe: PC held at 0x10 for 5 cycles, then 0x14.
  - Required: exactly 2 entries (0x10, 0x14).
- Overflow: DEPTH_LOG2=4, 20 distinct PCs, `rd_ready`=0.
  - Required: `count`=16, `drop_count`=4, and the stored entries are the first 16 PCs in order.
- Simultaneous push and pop when full: with `count`=16 and `rd_ready`=1, one new PC.
  - Required: `count` stays 16, `drop_count` unchanged, head advances by one entry.
- Async reset mid-stream: assert `rd_ni` low between clock edges with `count`=5.
  - Required: `count`=0 and `rd_valid`=0 without waiting for a clock edge.
  - After release, the next sample is captured even if its PC equals the previous one.
- `TRACE_LOOP_HALT_EN` defined: the retiring instruction at PC 0x40 is 32'h0000006F.
  - Required: that entry is stored, `halted`=1, and further distinct PCs are not captured.
  - Draining via `rd_ready` still works.
